// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller, extender and datapath.
// Contents: FSM state type, opcode constants, ALUOp type, mux-select and
// ALUControl encodings, and small decode helpers.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALUWB,
        S_BRANCH,
        S_TRAP
    } state_t;

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // funct3 values the ALU decoder understands for R-type / I-ALU.
    function automatic logic alu_funct3_legal(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b010, 3'b110, 3'b111: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_SW:     return IMM_S;
            OP_BRANCH: return IMM_B;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control decode.
// Ports: ALUOp (add/sub/funct), funct3, op5 (Instr[5]), funct7b5 (Instr[30])
//        -> ALUControl (3-bit ALU operation).
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] ALUOp,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] ALUControl
);

    always_comb begin
        ALUControl = ALU_ADD;
        case (ALUOp)
            ALUOP_SUB: ALUControl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // Only R-type (op5=1) can encode sub; addi's bit 30 is immediate.
                    3'b000:  ALUControl = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  ALUControl = ALU_SLT;
                    3'b110:  ALUControl = ALU_OR;
                    3'b111:  ALUControl = ALU_AND;
                    default: ALUControl = ALU_ADD;
                endcase
            end
            default:   ALUControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main controller of the multicycle RV32I core: Moore FSM plus instruction
// decode driving datapath selects, write enables and the extender ImmSrc.
// Ports: CLK, RST (async active-low); op/funct3/funct7b5 from the IR; Zero
//        from the ALU; MemReady memory handshake. Outputs: MemReq, AdrSrc,
//        IRWrite, PCWrite, RegWrite, MemWrite, ResultSrc, ALUSrcA, ALUSrcB,
//        ImmSrc, ALUControl, Trap (sticky illegal-instruction flag).
// RESET_TRAP_CLEAR=1: only reset leaves TRAP; 0: TRAP exits on MemReady.
module multicycle_control
    import riscv_ctrl_pkg::*;
#(
    parameter logic RESET_TRAP_CLEAR = 1'b1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       MemReq,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       Trap
);

    state_t state, next_state;
    aluop_t alu_op;

    logic is_lw, is_sw, is_r, is_i, is_br, is_beq, is_bne, legal;
    logic mem_req, ir_write, pc_write, reg_write, mem_write, trap;
    logic [1:0] imm_src;

    assign is_lw  = (op == OP_LW);
    assign is_sw  = (op == OP_SW);
    assign is_r   = (op == OP_RTYPE);
    assign is_i   = (op == OP_IALU);
    assign is_br  = (op == OP_BRANCH);
    assign is_beq = (funct3 == F3_BEQ);
    assign is_bne = (funct3 == F3_BNE);
    assign legal  = is_lw | is_sw
                  | ((is_r | is_i) & alu_funct3_legal(funct3))
                  | (is_br & (is_beq | is_bne));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= S_FETCH;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_FETCH:    if (MemReady) next_state = S_DECODE;
            S_DECODE: begin
                if (!legal)              next_state = S_TRAP;
                else if (is_lw | is_sw)  next_state = S_MEMADR;
                else if (is_r)           next_state = S_EXEC_R;
                else if (is_i)           next_state = S_EXEC_I;
                else                     next_state = S_BRANCH;
            end
            S_MEMADR:   next_state = is_lw ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (MemReady) next_state = S_MEMWB;
            S_MEMWRITE: if (MemReady) next_state = S_FETCH;
            S_EXEC_R,
            S_EXEC_I:   next_state = S_ALUWB;
            S_MEMWB,
            S_ALUWB,
            S_BRANCH:   next_state = S_FETCH;
            S_TRAP:     if (!RESET_TRAP_CLEAR && MemReady) next_state = S_FETCH;
            default:    next_state = S_FETCH;
        endcase
    end

    always_comb begin
        mem_req   = 1'b0;
        AdrSrc    = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        reg_write = 1'b0;
        mem_write = 1'b0;
        trap      = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RD2;
        alu_op    = ALUOP_ADD;
        imm_src   = imm_src_of(op);
        case (state)
            S_FETCH: begin
                mem_req   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                ir_write  = MemReady;
                pc_write  = MemReady;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                imm_src = IMM_B;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                reg_write = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                AdrSrc    = 1'b1;
                mem_write = 1'b1;
            end
            S_EXEC_R: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_RD2;
                alu_op  = ALUOP_FUNCT;
            end
            S_EXEC_I: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                alu_op  = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ResultSrc = RES_ALUOUT;
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA   = SRCA_RD1;
                ALUSrcB   = SRCB_RD2;
                alu_op    = ALUOP_SUB;
                ResultSrc = RES_ALUOUT;
                pc_write  = (is_beq & Zero) | (is_bne & ~Zero);
            end
            S_TRAP:  trap = 1'b1;
            default: ;
        endcase
    end

    // Enables are gated by RST directly so an asynchronous reset kills any
    // write in the same cycle, independent of the state register update.
    assign MemReq   = RST & mem_req;
    assign IRWrite  = RST & ir_write;
    assign PCWrite  = RST & pc_write;
    assign RegWrite = RST & reg_write;
    assign MemWrite = RST & mem_write;
    assign Trap     = RST & trap;
    assign ImmSrc   = RST ? imm_src : IMM_I;

    alu_decoder u_alu_decoder (
        .ALUOp      (alu_op),
        .funct3     (funct3),
        .op5        (op[5]),
        .funct7b5   (funct7b5),
        .ALUControl (ALUControl)
    );

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: a table of instructions with
// expected length / write counts / probe values, randomized instruction
// streams checked against a per-cycle trace model, and hand-written reset,
// abort and trap sequences.
module tb_multicycle_control;

    logic       CLK = 1'b0;
    logic       RST;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       MemReady;
    logic       MemReq, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, Trap;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;

    int vectors = 0;
    int miscompares = 0;

    multicycle_control #(.RESET_TRAP_CLEAR(1'b1)) dut (
        .CLK(CLK), .RST(RST), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .MemReady(MemReady), .MemReq(MemReq), .AdrSrc(AdrSrc),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl), .Trap(Trap)
    );

    always #5 CLK = ~CLK;

    // {MemReq,AdrSrc,IRWrite,PCWrite,RegWrite,MemWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,ALUControl,Trap}
    logic [17:0] act;
    assign act = {MemReq, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite,
                  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, Trap};

    localparam logic [17:0] NO_IMM = 18'h3FFCF;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                           IA = 7'b0010011, BR = 7'b1100011;

    function automatic logic [17:0] ov(input logic mreq, adr, irw, pcw, rw, mw,
                                       input logic [1:0] res, sa, sb, imm,
                                       input logic [2:0] alu, input logic trp);
        return {mreq, adr, irw, pcw, rw, mw, res, sa, sb, imm, alu, trp};
    endfunction

    function automatic logic [1:0] imm_for(input logic [6:0] o);
        if (o == SW) return 2'b01;
        if (o == BR) return 2'b10;
        return 2'b00;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // ---------------- trace model ----------------
    logic [17:0] exp_q[$];
    logic        rdy_q[$];

    task automatic push(input logic [17:0] v, input logic r);
        exp_q.push_back(v);
        rdy_q.push_back(r);
    endtask

    // cls: 0 lw, 1 sw, 2 R-type, 3 I-ALU, 4 branch
    task automatic model_instr(input int unsigned cls, input logic [2:0] alu,
                               input logic taken, input int unsigned fw, input int unsigned mwt);
        logic [1:0] imm;
        imm = (cls == 1) ? 2'b01 : (cls == 4) ? 2'b10 : 2'b00;
        repeat (fw) push(ov(1,0,0,0,0,0,2'b10,2'b00,2'b10,imm,3'b000,0), 1'b0);
        push(ov(1,0,1,1,0,0,2'b10,2'b00,2'b10,imm,3'b000,0), 1'b1);
        push(ov(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b10,3'b000,0), 1'($urandom));
        case (cls)
            0: begin
                push(ov(0,0,0,0,0,0,2'b00,2'b10,2'b01,imm,3'b000,0), 1'($urandom));
                repeat (mwt) push(ov(1,1,0,0,0,0,2'b00,2'b00,2'b00,imm,3'b000,0), 1'b0);
                push(ov(1,1,0,0,0,0,2'b00,2'b00,2'b00,imm,3'b000,0), 1'b1);
                push(ov(0,0,0,0,1,0,2'b01,2'b00,2'b00,imm,3'b000,0), 1'($urandom));
            end
            1: begin
                push(ov(0,0,0,0,0,0,2'b00,2'b10,2'b01,imm,3'b000,0), 1'($urandom));
                repeat (mwt) push(ov(1,1,0,0,0,1,2'b00,2'b00,2'b00,imm,3'b000,0), 1'b0);
                push(ov(1,1,0,0,0,1,2'b00,2'b00,2'b00,imm,3'b000,0), 1'b1);
            end
            2, 3: begin
                push(ov(0,0,0,0,0,0,2'b00,2'b10,(cls == 3) ? 2'b01 : 2'b00,imm,alu,0), 1'($urandom));
                push(ov(0,0,0,0,1,0,2'b00,2'b00,2'b00,imm,3'b000,0), 1'($urandom));
            end
            default:
                push(ov(0,0,0,taken,0,0,2'b00,2'b10,2'b00,imm,3'b001,0), 1'($urandom));
        endcase
    endtask

    task automatic run_trace(input string tag);
        for (int i = 0; i < exp_q.size(); i++) begin
            MemReady = rdy_q[i];
            @(negedge CLK);
            check($sformatf("%s c%0d", tag, i), 32'(act), 32'(exp_q[i]));
            @(posedge CLK); #1;
        end
        exp_q.delete();
        rdy_q.delete();
    endtask

    task automatic step_check(input string name, input logic [17:0] exp);
        @(negedge CLK);
        check(name, 32'(act), 32'(exp));
        @(posedge CLK); #1;
    endtask

    // Pulse reset starting at posedge+1; returns at posedge+1 in FETCH.
    task automatic reset_pulse(input string name);
        RST = 1'b0;
        #1 check({name, " in reset"}, 32'(act & NO_IMM), 32'(ov(0,0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0)));
        MemReady = 1'b1;
        @(posedge CLK); #1;
        @(negedge CLK);
        check({name, " held"}, 32'(act & NO_IMM), 32'(ov(0,0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0)));
        @(posedge CLK); #1;
        RST = 1'b1;
        @(negedge CLK);
        check({name, " refetch"}, 32'(act & NO_IMM), 32'(ov(1,0,1,1,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0)));
        MemReady = 1'b0;
        @(posedge CLK); #1;
    endtask

    typedef struct {
        string       name;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        zero;
        int unsigned len;
        int unsigned nrw;
        int unsigned nmw;
        logic [2:0]  alu2;
        logic        pcw2;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int unsigned cnt, nrw, nmw, cls, m;
        logic [2:0]  alu2, alu;
        logic        pcw2, taken, bne;

        tbl.push_back('{"lw",     LW, 3'b010, 1'b0, 1'b0, 5, 1, 0, 3'b000, 1'b0});
        tbl.push_back('{"sw",     SW, 3'b010, 1'b0, 1'b0, 4, 0, 1, 3'b000, 1'b0});
        tbl.push_back('{"add",    RT, 3'b000, 1'b0, 1'b0, 4, 1, 0, 3'b000, 1'b0});
        tbl.push_back('{"sub",    RT, 3'b000, 1'b1, 1'b0, 4, 1, 0, 3'b001, 1'b0});
        tbl.push_back('{"slt",    RT, 3'b010, 1'b0, 1'b0, 4, 1, 0, 3'b101, 1'b0});
        tbl.push_back('{"or",     RT, 3'b110, 1'b0, 1'b0, 4, 1, 0, 3'b011, 1'b0});
        tbl.push_back('{"and",    RT, 3'b111, 1'b0, 1'b0, 4, 1, 0, 3'b010, 1'b0});
        tbl.push_back('{"addi",   IA, 3'b000, 1'b1, 1'b0, 4, 1, 0, 3'b000, 1'b0});
        tbl.push_back('{"ori",    IA, 3'b110, 1'b0, 1'b1, 4, 1, 0, 3'b011, 1'b0});
        tbl.push_back('{"beq z1", BR, 3'b000, 1'b0, 1'b1, 3, 0, 0, 3'b001, 1'b1});
        tbl.push_back('{"beq z0", BR, 3'b000, 1'b0, 1'b0, 3, 0, 0, 3'b001, 1'b0});
        tbl.push_back('{"bne z1", BR, 3'b001, 1'b0, 1'b1, 3, 0, 0, 3'b001, 1'b0});
        tbl.push_back('{"bne z0", BR, 3'b001, 1'b0, 1'b0, 3, 0, 0, 3'b001, 1'b1});

        // Reset: 3 cycles with MemReady=1, then the first fetch writes IR and PC.
        RST = 1'b0; MemReady = 1'b1; op = LW; funct3 = 3'b010; funct7b5 = 1'b0; Zero = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check($sformatf("reset c%0d", i), 32'(act), 32'(ov(0,0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0)));
        end
        @(posedge CLK); #1;
        RST = 1'b1;
        @(negedge CLK);
        check("first fetch", 32'(act), 32'(ov(1,0,1,1,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0)));
        MemReady = 1'b0;
        @(posedge CLK); #1;

        // Table: each entry starts in FETCH, runs to the next IRWrite.
        foreach (tbl[e]) begin
            op = tbl[e].op; funct3 = tbl[e].f3; funct7b5 = tbl[e].f7; Zero = tbl[e].zero;
            MemReady = 1'b1;
            @(negedge CLK);
            check({tbl[e].name, " fetch"}, 32'(IRWrite), 32'd1);
            cnt = 1; nrw = 0; nmw = 0; alu2 = 3'bxxx; pcw2 = 1'bx;
            for (int k = 1; k <= 10; k++) begin
                @(posedge CLK); #1;
                @(negedge CLK);
                if (IRWrite) break;
                cnt++;
                nrw += 32'(RegWrite);
                nmw += 32'(MemWrite);
                if (k == 2) begin alu2 = ALUControl; pcw2 = PCWrite; end
            end
            check({tbl[e].name, " length"}, cnt, tbl[e].len);
            check({tbl[e].name, " regwrites"}, nrw, tbl[e].nrw);
            check({tbl[e].name, " memwrites"}, nmw, tbl[e].nmw);
            check({tbl[e].name, " alu@c2"}, 32'(alu2), 32'(tbl[e].alu2));
            check({tbl[e].name, " pcw@c2"}, 32'(pcw2), 32'(tbl[e].pcw2));
            MemReady = 1'b0;
            @(posedge CLK); #1;
        end

        // sw with two MemReady-low cycles in MEMWRITE; lw with fetch and read waits.
        op = SW; funct3 = 3'b010; funct7b5 = 1'b0;
        model_instr(1, 3'b000, 1'b0, 0, 2);
        run_trace("sw wait2");
        op = LW;
        model_instr(0, 3'b000, 1'b0, 1, 2);
        run_trace("lw waits");

        // Randomized instruction stream against the trace model.
        for (int n = 0; n < 60; n++) begin
            cls = $urandom_range(0, 4);
            Zero = 1'($urandom);
            funct3 = 3'($urandom);
            funct7b5 = 1'($urandom);
            alu = 3'b000; taken = 1'b0;
            case (cls)
                0: op = LW;
                1: op = SW;
                2: begin
                    op = RT; funct7b5 = 1'b0; m = $urandom_range(0, 4);
                    case (m)
                        0: begin funct3 = 3'b000; alu = 3'b000; end
                        1: begin funct3 = 3'b000; funct7b5 = 1'b1; alu = 3'b001; end
                        2: begin funct3 = 3'b010; alu = 3'b101; end
                        3: begin funct3 = 3'b110; alu = 3'b011; end
                        default: begin funct3 = 3'b111; alu = 3'b010; end
                    endcase
                end
                3: begin
                    op = IA; m = $urandom_range(0, 3);
                    case (m)
                        0: begin funct3 = 3'b000; alu = 3'b000; end
                        1: begin funct3 = 3'b010; alu = 3'b101; end
                        2: begin funct3 = 3'b110; alu = 3'b011; end
                        default: begin funct3 = 3'b111; alu = 3'b010; end
                    endcase
                end
                default: begin
                    op = BR; bne = 1'($urandom);
                    funct3 = bne ? 3'b001 : 3'b000;
                    taken = bne ? ~Zero : Zero;
                end
            endcase
            model_instr(cls, alu, taken, $urandom_range(0, 2), $urandom_range(0, 2));
            run_trace($sformatf("rand%0d", n));
        end

        // Reset mid-lw while MEMREAD is stalled: no RegWrite afterwards.
        op = LW; funct3 = 3'b010; MemReady = 1'b1;
        step_check("abort lw fetch",  ov(1,0,1,1,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
        step_check("abort lw decode", ov(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b10,3'b000,0));
        step_check("abort lw memadr", ov(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0));
        MemReady = 1'b0;
        step_check("abort lw memread", ov(1,1,0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0));
        reset_pulse("abort lw");

        // Reset mid-sw while MEMWRITE is stalled: MemWrite drops at once.
        op = SW; MemReady = 1'b1;
        step_check("abort sw fetch",  ov(1,0,1,1,0,0,2'b10,2'b00,2'b10,2'b01,3'b000,0));
        step_check("abort sw decode", ov(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b10,3'b000,0));
        step_check("abort sw memadr", ov(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b01,3'b000,0));
        MemReady = 1'b0;
        step_check("abort sw memwrite", ov(1,1,0,0,0,1,2'b00,2'b00,2'b00,2'b01,3'b000,0));
        reset_pulse("abort sw");

        // Illegal encodings: trap after DECODE, sticky until reset.
        for (int t = 0; t < 4; t++) begin
            case (t)
                0: begin op = 7'b1111111; funct3 = 3'b000; end
                1: begin op = RT; funct3 = 3'b001; end
                2: begin op = IA; funct3 = 3'b101; end
                default: begin op = BR; funct3 = 3'b100; end
            endcase
            funct7b5 = 1'b0; MemReady = 1'b1;
            step_check($sformatf("trap%0d fetch", t), ov(1,0,1,1,0,0,2'b10,2'b00,2'b10,imm_for(op),3'b000,0));
            step_check($sformatf("trap%0d decode", t), ov(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b10,3'b000,0));
            for (int c = 0; c < 4; c++) begin
                MemReady = 1'($urandom);
                step_check($sformatf("trap%0d hold%0d", t, c), ov(0,0,0,0,0,0,2'b00,2'b00,2'b00,imm_for(op),3'b000,1));
            end
            reset_pulse($sformatf("trap%0d clear", t));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main controller for the multicycle RV32I core variant. It reuses one ALU, one memory port and the immediate extender across several cycles per instruction.
- A Moore FSM plus combinational instruction/ALU decode drives the datapath mux selects, write enables and the extender's 2-bit ImmSrc.
- Sits between the instruction register and the datapath. Handles memory wait states via a ready handshake and traps illegal instructions.

Parameters:
- RESET_TRAP_CLEAR, 1, when 1 only RST leaves TRAP; when 0 TRAP also returns to FETCH on next MemReady (debug builds)

Ports:
- CLK  input  1  rising-edge clock
- RST  input  1  asynchronous, active-low reset
- op  input  7  Instr[6:0] from instruction register
- funct3  input  3  Instr[14:12]
- funct7b5  input  1  Instr[30]
- Zero  input  1  ALU zero flag
- MemReady  input  1  memory completed current access this cycle
- MemReq  output  1  memory access in progress
- AdrSrc  output  1  0=PC, 1=Result as memory address
- IRWrite  output  1  load instruction register (also latches OldPC)
- PCWrite  output  1  load PC with Result
- RegWrite  output  1  register file write
- MemWrite  output  1  store strobe
- ResultSrc  output  2  00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  output  2  00=PC, 01=OldPC, 10=RD1
- ALUSrcB  output  2  00=RD2, 01=ImmExt, 10=constant 4
- ImmSrc  output  2  00=I, 01=S, 10=B, 11 never driven
- ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- Trap  output  1  illegal instruction seen; sticky

Behaviour:
- Reset (RST=0): state=FETCH immediately. All enables (IRWrite, PCWrite, RegWrite, MemWrite, MemReq) are forced 0 while RST=0, regardless of state. Trap=0.
- Selects at reset are the FETCH values: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, ALUControl=000, ImmSrc=00.
- Supported opcodes: lw 0000011, sw 0100011, R-type 0110011, I-ALU 0010011, branch 1100011 (funct3 000 beq, 001 bne).
- Any other opcode, or a branch with another funct3, is illegal.
- ImmSrc decode is by op in every state: lw/I-ALU→00, sw→01, branch→10, else 00. In DECODE it is always 10.
- States, with non-default outputs (defaults are 0/00):
  - FETCH: MemReq=1, ALUSrcB=10, ResultSrc=10, ALUOp=add. IRWrite=PCWrite=MemReady. Stays in FETCH while MemReady=0; goes to DECODE on MemReady=1.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ImmSrc=10, add (branch target to ALUOut). Next state: lw/sw→MEMADR, R→EXEC_R, I-ALU→EXEC_I, legal branch→BRANCH, illegal→TRAP.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, add. Next: lw→MEMREAD, sw→MEMWRITE.
  - MEMREAD: MemReq=1, AdrSrc=1. Holds until MemReady, then goes to MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1 → FETCH.
  - MEMWRITE: MemReq=1, AdrSrc=1, MemWrite=1, held until MemReady, then → FETCH.
  - EXEC_R: ALUSrcA=10, ALUSrcB=00, ALUOp=funct → ALUWB.
  - EXEC_I: ALUSrcA=10, ALUSrcB=01, ALUOp=funct → ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1 → FETCH.
  - BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00. PCWrite = (beq & Zero) | (bne & ~Zero). → FETCH.
  - TRAP: Trap=1, all enables 0. Exit per RESET_TRAP_CLEAR.
- ALU decode:
  - ALUOp=add→000; sub→001.
  - funct: funct3 000 → 001 if (op[5] & funct7b5) else 000; 010→101; 110→011; 111→010.
  - Any other funct3 in EXEC_R/EXEC_I is treated as illegal: the DECODE transition goes to TRAP.
- Latency at MemReady=1 throughout: lw 5 cycles, sw 4, R/I 4, branch 3.
- Each memory wait cycle adds exactly 1 cycle and holds all outputs stable.
- Asynchronous RST mid-instruction aborts the instruction: no partial RegWrite/MemWrite occurs after RST falls.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - state encoding (4-bit enum)
  - opcode constants
  - ImmSrc, ResultSrc, ALUSrcA/B and ALUControl encodings, shared with the extender and datapath
- Sub-module alu_decoder: combinational (ALUOp, funct3, op[5], funct7b5) → ALUControl.
- FSM and instruction decode stay in multicycle_control.

Test Plan:
- Reset: hold RST=0 with MemReady=1 for 3 cycles, release → all enables 0 during reset; IRWrite=PCWrite=1 in first post-reset cycle.
- lw (op 0000011), MemReady=1 → states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. ImmSrc=00 in MEMADR. Exactly one RegWrite pulse, with ResultSrc=01, on cycle 5.
- sw with MemReady low 2 cycles in MEMWRITE → MemWrite=1 for 3 consecutive cycles; ImmSrc=01 in MEMADR; no RegWrite.
- R-type sub (funct3 000, funct7b5=1) → ALUControl=001 in EXEC_R. Same with op 0010011 (addi, funct7b5=1) → 000.
- beq: Zero=1 → PCWrite=1 in BRANCH; Zero=0 → PCWrite=0. bne gives the inverse. DECODE shows ImmSrc=10, ALUSrcA=01.
- op 1111111 → TRAP after DECODE with Trap=1 and no enables. Remains there with RESET_TRAP_CLEAR=1 until RST pulse.
